mult_share_arbiter: RTL
=======================

// Module: mult_share_arbiter
// PURPOSE
//   Shares one pipelined BITSxBITS unsigned multiplier among NREQ requesters.
//   Round-robin arbitration, valid/ready handshake per requester, single response
//   port tagged with requester id, whole-pipe stall under response backpressure.
//   Sits in front of the multiplier datapath of the micro benchmark set, replacing
//   per-consumer multipliers with a single scheduled one.
// PARAMETERS
//   BITS   8   operand width; product width is 2*BITS
//   NREQ   4   number of requesters (power of two, >=2)
//   IDW    2   requester-id width = log2(NREQ)
//   LAT    2   accept-to-response latency in cycles (>=1)
// PORTS
//   clock      in   1          rising-edge clock
//   reset_n    in   1          asynchronous, active-low reset
//   req_valid  in   NREQ       per-requester operand valid
//   req_ready  out  NREQ       per-requester accept (one-hot or zero)
//   req_a      in   NREQ*BITS  operand a, requester i at [i*BITS +: BITS]
//   req_b      in   NREQ*BITS  operand b, same packing
//   rsp_valid  out  1          product valid
//   rsp_ready  in   1          consumer accepts product
//   rsp_id     out  IDW        requester that issued the product
//   rsp_data   out  2*BITS     a*b, unsigned, full width, never truncated
//   busy       out  1          any pipeline stage holds a valid op
//   op_count   out  16         completed ops (rsp_valid & rsp_ready), wraps at 2^16
// BEHAVIOUR
//   - Reset values: req_ready 0, rsp_valid 0, rsp_id 0, rsp_data 0, busy 0,
//     op_count 0, round-robin pointer 0 (requester 0 highest priority).
//   - stall = rsp_valid & ~rsp_ready. While stall: all req_ready 0, every stage
//     holds (valid, id, data unchanged), op_count unchanged.
//   - Arbitration (combinational from req_valid, pointer): first i with
//     req_valid[i], searching ptr, ptr+1, ... mod NREQ. req_ready[i] = grant[i] & ~stall.
//   - Transfer = req_valid[i] & req_ready[i]; at most one per cycle. On transfer
//     pointer <= granted+1 mod NREQ; otherwise pointer unchanged.
//   - Latency: op accepted at edge T appears on rsp_valid/rsp_id/rsp_data after
//     edge T+LAT-1 (no stall); each stall cycle adds one cycle. Order preserved.
//   - Without stall the pipe advances every cycle; idle cycles enter as bubbles
//     (valid 0). Throughput 1 op/cycle.
//   - rsp_data/rsp_id held stable while rsp_valid & ~rsp_ready; undefined content
//     never shown: when rsp_valid is 0, rsp_id/rsp_data keep last value.
//   - Requester may drop req_valid without acceptance; no state retained.
//   - op_count increments on each rsp_valid & rsp_ready; 16'hFFFF -> 16'h0000.
//   - reset_n low mid-operation: all in-flight ops dropped immediately, outputs to
//     reset values asynchronously; after release no stale rsp_valid appears.
// STRUCTURE
//   - Shared header (`include): `define BITS, NREQ, IDW, LAT defaults, product
//     width macro; no other shared types.
//   - Sub-module mult_pipe: LAT-stage multiplier with enable (= ~stall), carries
//     valid and id alongside product; stage 1 registers a*b, later stages delay.
//   - Top: round-robin grant logic, pointer register, stall, op_count.
// TESTING
//   1. req0 a=12 b=11 alone, accepted at edge T -> rsp_valid after T+1, id 0,
//      data 16'd132, op_count 1.
//   2. All 4 valid continuously, a=i+1 b=3, rsp_ready 1 -> grants 0,1,2,3,0,...;
//      responses back-to-back ids 0,1,2,3 data 3,6,9,12.
//   3. Pipe full, rsp_ready 0 for 3 cycles -> rsp_id/rsp_data held, req_ready 0,
//      op_count frozen; on release remaining ops drain in order, none lost/dup.
//   4. a=255 b=255 -> rsp_data 16'hFE01; a=0 b=200 -> 16'h0000.
//   5. Only req1, req3 continuously valid -> grant sequence 1,3,1,3,...
//   6. reset_n low with 2 ops in flight -> outputs 0 at once; after release,
//      no rsp_valid until new request, first grant goes to lowest valid index.

Source files
------------

// File: rtl/mult_share_arbiter_pkg.sv
// Shared defaults for the shared-multiplier arbiter and its pipeline.
package mult_share_arbiter_pkg;

    localparam int unsigned DEF_BITS = 8;
    localparam int unsigned DEF_NREQ = 4;
    localparam int unsigned DEF_IDW  = 2;
    localparam int unsigned DEF_LAT  = 2;

    // Full-width unsigned product of two operands of the given width.
    function automatic int unsigned prod_width(input int unsigned bits);
        return 2 * bits;
    endfunction

endpackage

// File: rtl/mult_share_arbiter_mult_pipe.sv
// LAT-stage unsigned multiplier; valid and id travel with the product.
module mult_share_arbiter_mult_pipe
    import mult_share_arbiter_pkg::*;
#(
    parameter int unsigned BITS = DEF_BITS,
    parameter int unsigned IDW  = DEF_IDW,
    parameter int unsigned LAT  = DEF_LAT
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              en,
    input  logic              op_valid,
    input  logic [IDW-1:0]    op_id,
    input  logic [BITS-1:0]   op_a,
    input  logic [BITS-1:0]   op_b,
    output logic              res_valid,
    output logic [IDW-1:0]    res_id,
    output logic [2*BITS-1:0] res_data,
    output logic              busy
);

    localparam int unsigned PW = prod_width(BITS);

    logic [LAT-1:0] valid_q;
    logic [IDW-1:0] id_q   [LAT];
    logic [PW-1:0]  data_q [LAT];

    // Payload only moves with a valid op, so the output keeps its last shown value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                id_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else if (en) begin
            valid_q[0] <= op_valid;
            if (op_valid) begin
                id_q[0]   <= op_id;
                data_q[0] <= PW'(op_a) * PW'(op_b);
            end
            for (int i = 1; i < LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    id_q[i]   <= id_q[i-1];
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign res_valid = valid_q[LAT-1];
    assign res_id    = id_q[LAT-1];
    assign res_data  = data_q[LAT-1];
    assign busy      = |valid_q;

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one pipelined multiplier among NREQ requesters,
// with whole-pipe stall under response backpressure.
module mult_share_arbiter
    import mult_share_arbiter_pkg::*;
#(
    parameter int unsigned BITS = DEF_BITS,
    parameter int unsigned NREQ = DEF_NREQ,
    parameter int unsigned IDW  = DEF_IDW,
    parameter int unsigned LAT  = DEF_LAT
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*BITS-1:0] req_a,
    input  logic [NREQ*BITS-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [2*BITS-1:0]    rsp_data,
    output logic                 busy,
    output logic [15:0]          op_count
);

    logic [IDW-1:0]  ptr_q;
    logic [IDW-1:0]  grant_id;
    logic [IDW-1:0]  idx;
    logic            found;
    logic            stall;
    logic            xfer;
    logic [BITS-1:0] sel_a;
    logic [BITS-1:0] sel_b;

    assign stall = rsp_valid & ~rsp_ready;
    assign xfer  = found & ~stall;

    // First valid requester at or after the pointer; index wraps in IDW bits.
    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        idx      = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr_q + IDW'(k);
            if (!found && req_valid[idx]) begin
                found    = 1'b1;
                grant_id = idx;
            end
        end
    end

    // Ready is forced low while reset is asserted so it matches the reset state.
    always_comb begin
        req_ready = '0;
        if (found && !stall && reset_n) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == IDW'(i)) begin
                sel_a = req_a[i*BITS +: BITS];
                sel_b = req_b[i*BITS +: BITS];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q    <= '0;
            op_count <= '0;
        end else begin
            if (xfer) begin
                ptr_q <= grant_id + IDW'(1);
            end
            if (rsp_valid && rsp_ready) begin
                op_count <= op_count + 16'd1;
            end
        end
    end

    mult_share_arbiter_mult_pipe #(
        .BITS (BITS),
        .IDW  (IDW),
        .LAT  (LAT)
    ) u_pipe (
        .clock     (clock),
        .reset_n   (reset_n),
        .en        (~stall),
        .op_valid  (xfer),
        .op_id     (grant_id),
        .op_a      (sel_a),
        .op_b      (sel_b),
        .res_valid (rsp_valid),
        .res_id    (rsp_id),
        .res_data  (rsp_data),
        .busy      (busy)
    );

endmodule
